// File: rtl/slice_word_assembler_pkg.sv
// Shared definitions for the bit-sliced stream converters.
// Holds default geometry, derived counts and the collector state enum.
package slice_word_assembler_pkg;

  localparam int WORD_DEF  = 16;
  localparam int SLICE_DEF = 4;
  localparam int PE_DEF    = 2;

  localparam int SLICES = WORD_DEF / SLICE_DEF;
  localparam int CNT_W  = $clog2(SLICES + 1);
  localparam int LANES  = 2 * PE_DEF;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

endpackage

// File: rtl/slice_lane_shifter.sv
// Per-lane work register: writes one slice per beat and
// presents the extended word during the final beat.
module slice_lane_shifter #(
  parameter int W  = 16,
  parameter int S  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic          last_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] prec_i,
  input  logic          sext_i,
  input  logic [S-1:0]  slice_i,
  output logic [W-1:0]  word_o
);

  localparam int NS = W / S;

  logic [W-1:0] work_q, work_d, merged;
  logic         msb;

  always_comb begin
    merged = work_q;
    for (int k = 0; k < NS; k++) begin
      if (cnt_i == CW'(k)) merged[k*S +: S] = slice_i;
    end
    msb = 1'b0;
    for (int k = 1; k <= NS; k++) begin
      if (prec_i == CW'(k)) msb = merged[k*S-1];
    end
    word_o = merged;
    for (int b = 0; b < W; b++) begin
      if (b >= int'(prec_i) * S) word_o[b] = sext_i & msb;
    end
  end

  always_comb begin
    work_d = work_q;
    if (clr_i || (wr_i && last_i)) work_d = '0;
    else if (wr_i) work_d = merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) work_q <= '0;
    else       work_q <= work_d;
  end

endmodule

// File: rtl/slice_word_assembler.sv
// Rebuilds parallel words from LSB-first slice beats on 2*PE lanes,
// with a one-word output buffer decoupling collection from the consumer.
module slice_word_assembler
  import slice_word_assembler_pkg::*;
#(
  parameter int MAX_WORD_LENGTH = WORD_DEF,
  parameter int Slice_Size      = SLICE_DEF,
  parameter int PE              = PE_DEF,
  localparam int W  = MAX_WORD_LENGTH,
  localparam int S  = Slice_Size,
  localparam int NS = W / S,
  localparam int CW = $clog2(NS + 1),
  localparam int NL = 2 * PE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] prec,
  input  logic          signed_mode,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [S*NL-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W*NL-1:0] m_data,
  output logic          busy
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   prec_q, prec_d, prec_n;
  logic            signed_q, signed_d;
  logic            mvalid_q, mvalid_d;
  logic [W*NL-1:0] mdata_q, mdata_d, words;
  logic            last, acc, fin;

  always_comb begin
    prec_n = prec;
    if (prec == '0 || prec > CW'(NS)) prec_n = CW'(NS);
  end

  assign last = (cnt_q == prec_q - CW'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prec_d   = prec_q;
    signed_d = signed_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    s_ready  = 1'b0;
    acc      = 1'b0;
    fin      = 1'b0;
    if (start) begin
      state_d  = COLLECT;
      cnt_d    = '0;
      prec_d   = prec_n;
      signed_d = signed_mode;
    end else if (state_q == COLLECT) begin
      // Only the final beat needs room in the output buffer.
      s_ready = !last || !mvalid_q || m_ready;
      acc     = s_valid && s_ready;
      fin     = acc && last;
      if (acc) cnt_d = last ? '0 : cnt_q + CW'(1);
    end
    if (mvalid_q && m_ready) mvalid_d = 1'b0;
    if (fin) begin
      mvalid_d = 1'b1;
      mdata_d  = words;
    end
  end

  for (genvar j = 0; j < NL; j++) begin : g_lane
    slice_lane_shifter #(
      .W (W),
      .S (S),
      .CW(CW)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (start),
      .wr_i   (acc),
      .last_i (last),
      .cnt_i  (cnt_q),
      .prec_i (prec_q),
      .sext_i (signed_q),
      .slice_i(s_data[j*S +: S]),
      .word_o (words[j*W +: W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prec_q   <= CW'(NS);
      signed_q <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prec_q   <= prec_d;
      signed_q <= signed_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
    end
  end

  assign m_valid = mvalid_q;
  assign m_data  = mdata_q;
  assign busy    = (cnt_q != '0);

endmodule
